// File: rtl/md_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | md_unit_if : EX-stage multiply/divide request and result bundle     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface md_unit_if;
   logic [3:0]  MDop;
   logic [31:0] A;
   logic [31:0] B;
   logic        start;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MD_out;

   modport master (output MDop, A, B, input start, busy, HI, LO, MD_out);
   modport slave  (input MDop, A, B, output start, busy, HI, LO, MD_out);
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | md_unit : MIPS HI/LO multiply/divide unit with fixed-latency busy   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset,
   md_unit_if.slave  md
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   thi_q, thi_d, tlo_q, tlo_d;
   logic          twe_q, twe_d;

   logic          is_md_op, is_mult, start_w;
   logic signed [63:0] prod_s;
   logic [63:0]   prod_u;
   logic [31:0]   quo_s, rem_s, quo_u, rem_u;
   logic [31:0]   res_hi, res_lo;
   logic          res_we;

   assign is_md_op = md.MDop inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
   assign is_mult  = (md.MDop == OP_MULT) || (md.MDop == OP_MULTU);
   assign start_w  = is_md_op && (state_q == S_IDLE) && !reset;

   assign prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
   assign prod_u = {32'd0, md.A} * {32'd0, md.B};
   assign quo_s  = $signed(md.A) / $signed(md.B);
   assign rem_s  = $signed(md.A) % $signed(md.B);
   assign quo_u  = md.A / md.B;
   assign rem_u  = md.A % md.B;

   // A zero divisor still occupies the unit but must leave HI/LO untouched.
   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      res_we = 1'b0;
      case (md.MDop)
         OP_MULT:  begin {res_hi, res_lo} = prod_s; res_we = 1'b1; end
         OP_MULTU: begin {res_hi, res_lo} = prod_u; res_we = 1'b1; end
         OP_DIV:   begin res_hi = rem_s; res_lo = quo_s; res_we = (md.B != 32'd0); end
         OP_DIVU:  begin res_hi = rem_u; res_lo = quo_u; res_we = (md.B != 32'd0); end
         default:  ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      thi_d   = thi_q;
      tlo_d   = tlo_q;
      twe_d   = twe_q;
      case (state_q)
         S_IDLE: begin
            if (start_w) begin
               thi_d   = res_hi;
               tlo_d   = res_lo;
               twe_d   = res_we;
               cnt_d   = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
               state_d = S_RUN;
            end else if (md.MDop == OP_MTHI) begin
               hi_d = md.A;
            end else if (md.MDop == OP_MTLO) begin
               lo_d = md.A;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               if (twe_q) begin
                  hi_d = thi_q;
                  lo_d = tlo_q;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         thi_q   <= 32'd0;
         tlo_q   <= 32'd0;
         twe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         thi_q   <= thi_d;
         tlo_q   <= tlo_d;
         twe_q   <= twe_d;
      end
   end

   assign md.start  = start_w;
   assign md.busy   = (state_q == S_RUN);
   assign md.HI     = hi_q;
   assign md.LO     = lo_q;
   assign md.MD_out = (md.MDop == OP_MFHI) ? hi_q :
                      (md.MDop == OP_MFLO) ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_md_unit : directed and random checks of md_unit against a model  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_md_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   md_unit_if mdif ();
   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mdif.slave)
   );

   int checks   = 0;
   int failures = 0;
   logic [31:0] m_hi, m_lo;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Architectural effect of one accepted instruction on HI/LO.
   function automatic void model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      longint unsigned ua, ub, pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      case (op)
         4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
         4'd2: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; end
         4'd3: if (b != 32'd0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
         4'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
         4'd7: m_hi = a;
         4'd8: m_lo = a;
         default: ;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (mdif.busy === 1'b1 && n < 200) begin
         n++;
         tick();
      end
   endtask

   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      mdif.MDop = op; mdif.A = a; mdif.B = b;
      #1 chk({tag, "_start"}, {31'd0, mdif.start}, 32'd1);
      model_exec(op, a, b);
      tick();
      mdif.MDop = 4'd0;
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      int n;
      launch(op, a, b, tag);
      count_busy(n);
      chk({tag, "_busy_cycles"}, 32'(n), (op <= 4'd2) ? 32'(MC) : 32'(DC));
      chk({tag, "_hi"}, mdif.HI, m_hi);
      chk({tag, "_lo"}, mdif.LO, m_lo);
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] a, input string tag);
      mdif.MDop = op; mdif.A = a;
      #1 chk({tag, "_start"}, {31'd0, mdif.start}, 32'd0);
      model_exec(op, a, 32'd0);
      tick();
      mdif.MDop = 4'd0;
      chk({tag, "_hi"}, mdif.HI, m_hi);
      chk({tag, "_lo"}, mdif.LO, m_lo);
   endtask

   task automatic mf(input logic [3:0] op, input string tag);
      mdif.MDop = op;
      #1 chk({tag, "_md_out"}, mdif.MD_out, (op == 4'd5) ? m_hi : m_lo);
      tick();
      mdif.MDop = 4'd0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   initial begin
      int n;
      logic [3:0] op;
      logic [31:0] a, b;

      reset = 1'b1;
      mdif.MDop = 4'd1; mdif.A = 32'd3; mdif.B = 32'd3;
      @(negedge clk);
      #1 chk("reset_start_blocked", {31'd0, mdif.start}, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      mdif.MDop = 4'd0;
      m_hi = 32'd0; m_lo = 32'd0;
      #1;
      chk("reset_busy", {31'd0, mdif.busy}, 32'd0);
      chk("reset_hi", mdif.HI, 32'd0);
      chk("reset_lo", mdif.LO, 32'd0);
      chk("reset_md_out", mdif.MD_out, 32'd0);

      run_op(4'd1, 32'hFFFFFFFF, 32'h2, "mult");
      chk("mult_hi_const", mdif.HI, 32'hFFFFFFFF);
      chk("mult_lo_const", mdif.LO, 32'hFFFFFFFE);
      mf(4'd5, "mfhi");

      run_op(4'd2, 32'hFFFFFFFF, 32'h2, "multu");
      chk("multu_hi_const", mdif.HI, 32'h1);
      chk("multu_lo_const", mdif.LO, 32'hFFFFFFFE);
      mf(4'd6, "mflo");

      run_op(4'd3, 32'hFFFFFFF9, 32'h2, "div_neg");
      chk("div_lo_const", mdif.LO, 32'hFFFFFFFD);
      chk("div_hi_const", mdif.HI, 32'hFFFFFFFF);

      run_op(4'd4, 32'd7, 32'd2, "divu");
      chk("divu_lo_const", mdif.LO, 32'd3);
      chk("divu_hi_const", mdif.HI, 32'd1);

      mt(4'd7, 32'h12345678, "mthi");
      run_op(4'd4, 32'd5, 32'd0, "divu_zero");
      chk("divzero_hi_const", mdif.HI, 32'h12345678);
      chk("divzero_lo_const", mdif.LO, 32'd3);

      // Requests arriving while busy must be dropped.
      launch(4'd3, 32'd100, 32'd7, "div_interf");
      chk("interf_busy1", {31'd0, mdif.busy}, 32'd1);
      mdif.MDop = 4'd8; mdif.A = 32'hDEAD;
      #1 chk("interf_mtlo_start", {31'd0, mdif.start}, 32'd0);
      tick();
      chk("interf_busy2", {31'd0, mdif.busy}, 32'd1);
      mdif.MDop = 4'd1; mdif.A = 32'd3; mdif.B = 32'd3;
      #1 chk("interf_mult_start", {31'd0, mdif.start}, 32'd0);
      tick();
      mdif.MDop = 4'd0;
      count_busy(n);
      chk("interf_busy_cycles", 32'(n + 2), 32'(DC));
      chk("interf_lo", mdif.LO, 32'd14);
      chk("interf_hi", mdif.HI, 32'd2);

      mdif.MDop = 4'd12;
      #1 chk("nop12_start", {31'd0, mdif.start}, 32'd0);
      chk("nop12_md_out", mdif.MD_out, 32'd0);
      tick();
      mdif.MDop = 4'd0;
      chk("nop12_busy", {31'd0, mdif.busy}, 32'd0);
      chk("nop12_hi", mdif.HI, m_hi);

      // Reset on the third busy cycle discards the in-flight multiply.
      launch(4'd1, 32'd3, 32'd3, "mult_rst");
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      #1;
      chk("midrst_busy", {31'd0, mdif.busy}, 32'd0);
      chk("midrst_hi", mdif.HI, 32'd0);
      chk("midrst_lo", mdif.LO, 32'd0);
      repeat (8) tick();
      chk("midrst_late_hi", mdif.HI, 32'd0);
      chk("midrst_late_lo", mdif.LO, 32'd0);
      run_op(4'd1, 32'd3, 32'd3, "mult_after_rst");
      chk("after_rst_lo_const", mdif.LO, 32'd9);

      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(1, 8));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 9));
            2:       b = -32'($urandom_range(1, 9));
            default: b = $urandom;
         endcase
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
         if (op <= 4'd4)      run_op(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
         else if (op <= 4'd6) mf(op, $sformatf("rnd%0d_op%0d", i, op));
         else                 mt(op, a, $sformatf("rnd%0d_op%0d", i, op));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the 4-bit MDop decoded by the controller, plus the forwarded rs/rt operands.
- Holds the architectural HI/LO registers and models the multi-cycle latency of mult/div with a busy counter.
- Exposes start/busy so the hazard unit can stall a later MD-class instruction in D.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >=1)
DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
MDop  in  4  MD operation of the instruction in EX: 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 treated as nop
A  in  32  forwarded rs value
B  in  32  forwarded rt value
start  out  1  combinational; high when MDop is 1-4 and busy=0 and reset=0
busy  out  1  registered; high while a mult/div is in flight
HI  out  32  committed HI register
LO  out  32  committed LO register
MD_out  out  32  HI when MDop=5, LO when MDop=6, else 0; combinational from committed regs

Behaviour:
- Reset (edge with reset=1): HI=0, LO=0, busy=0, counter=0, shadow regs=0. Any in-flight operation is discarded. reset overrides every other input on that edge.
- Two states, IDLE (busy=0) and RUN (busy=1).
- IDLE, start=1 at an edge:
  - Latch the computed result into shadow regs tHI/tLO.
  - Load counter with MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4).
  - busy=1 from the next cycle.
- RUN, each edge: counter decrements. On the edge where counter==1, HI<=tHI, LO<=tLO, busy<=0, return to IDLE.
  - busy is therefore high exactly N cycles after the start edge.
  - New HI/LO values are visible on the first cycle busy is low.
- Arithmetic:
  - mult: {HI,LO} = signed A × signed B (64-bit).
  - multu: the unsigned 64-bit product.
  - div: LO = A/B, HI = A%B, signed; quotient truncates toward zero, remainder takes the sign of A.
  - divu: the unsigned quotient/remainder.
  - Div/divu with B==0: still busy for DIV_CYCLES; HI/LO left unchanged at completion.
- mthi/mtlo in IDLE: HI<=A (7) or LO<=A (8) at the edge, visible the next cycle. mthi/mtlo while busy=1: ignored.
- MDop 1-4 while busy=1: ignored (start=0, no relaunch). The hazard unit guarantees this never occurs; the bench flags it.
- mfhi/mflo while busy: MD_out returns the old committed value. The hazard unit stalls these, so the value is unused.
- Start on the same edge that busy falls: impossible by construction, since busy is registered and still 1 on that edge. The new op starts on the following edge.
- Hazard contract, implemented outside this block: stall D iff the D instruction is MD-class (mult/div/mf/mt) and (start|busy).
- No flush input. An EX bubble presents MDop=0.

Test Plan:
- mult A=0xFFFFFFFF B=0x00000002 -> start=1 for one cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; mfhi MD_out=0xFFFFFFFF.
- multu, same operands -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7 B=2 -> LO=3, HI=1.
- mthi A=0x12345678, then divu A=5 B=0 -> busy 10 cycles; HI stays 0x12345678, LO stays its prior value.
- div A=100 B=7; then mtlo A=0xDEAD and mult A=3 B=3 presented on the next cycles while busy -> both ignored; final LO=14, HI=2; busy drops after exactly 10 cycles.
- mult 3×3 started; reset asserted on the 3rd busy cycle -> next cycle busy=0, HI=LO=0; no late HI/LO write afterwards. Then mult 3×3 -> LO=9 after 5 cycles.
